// File: rtl/cla_serial_adder_pkg.sv
// Shared definitions for the nibble-serial CLA adder: FSM encodings, digit width, overflow helper.
package cla_serial_adder_pkg;

  localparam int unsigned NIB_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Two's-complement overflow from the operand and sum sign bits
  function automatic logic ovf_of(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_serial_adder_if.sv
// Operand/result handshake bundle for cla_serial_adder; sub exists only when SUBTRACT_EN is defined.
interface cla_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SUBTRACT_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin,
`ifdef SUBTRACT_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef SUBTRACT_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_serial_adder_cla4.sv
// 4-bit carry-lookahead adder slice with group propagate/generate outputs.
module cla_serial_adder_cla4
  import cla_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co,
  output logic             pg,
  output logic             gg
);
  logic [NIB_W-1:0] p;
  logic [NIB_W-1:0] g;
  logic [NIB_W:0]   c;

  assign p    = a ^ b;
  assign g    = a & b;
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pg   = &p;
  assign c[4] = gg | (pg & c[0]);
  assign s    = p ^ c[NIB_W-1:0];
  assign co   = c[NIB_W];

endmodule

// File: rtl/cla_serial_adder.sv
// Nibble-serial WIDTH-bit adder: one CLA4 slice, registered carry, valid/ready in and out.
// Define SUBTRACT_EN to add the sub input (b inverted and cin forced to 1 at latch time).
module cla_serial_adder
  import cla_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  cla_serial_adder_if.slave bus
);
  localparam int unsigned NIBS  = WIDTH / NIB_W;
  localparam int unsigned CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic             accept_c;
  logic             last_c;
  logic             release_c;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nx;
  logic             carry;
  logic [CNT_W-1:0] count;

  logic [NIB_W-1:0] nib_s;
  logic             nib_co;
  logic             pg;
  logic             gg;
  logic             unused_pg_gg;

  cla_serial_adder_cla4 u_cla4 (
    .a  (a_sh[NIB_W-1:0]),
    .b  (b_sh[NIB_W-1:0]),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co),
    .pg (pg),
    .gg (gg)
  );

  assign unused_pg_gg = pg ^ gg;

  // Result digit enters at the MSB end so the last digit lands in the top nibble
  assign sum_nx = (sum_sh >> NIB_W) | (WIDTH'(nib_s) << (WIDTH - NIB_W));

  assign bus.in_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    release_c = 1'b0;
    case (state)
      ST_IDLE: if (bus.in_valid) begin
        accept_c = 1'b1;
        state_nx = ST_RUN;
      end
      ST_RUN: if (count == CNT_W'(NIBS - 1)) begin
        last_c   = 1'b1;
        state_nx = ST_DONE;
      end
      ST_DONE: if (bus.out_valid && bus.out_ready) begin
        release_c = 1'b1;
        state_nx  = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand shift registers, carry and digit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      count  <= '0;
    end else if (accept_c) begin
      a_sh  <= bus.a;
`ifdef SUBTRACT_EN
      b_sh  <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub | bus.cin;
`else
      b_sh  <= bus.b;
      carry <= bus.cin;
`endif
      count <= '0;
    end else if (state == ST_RUN) begin
      a_sh   <= a_sh >> NIB_W;
      b_sh   <= b_sh >> NIB_W;
      sum_sh <= sum_nx;
      carry  <= nib_co;
      count  <= count + CNT_W'(1);
    end
  end

  // Result registers hold until the next operation completes; the top digit still sits in a_sh/b_sh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (last_c) begin
      bus.sum       <= sum_nx;
      bus.cout      <= nib_co;
      bus.ovf       <= ovf_of(a_sh[NIB_W-1], b_sh[NIB_W-1], nib_s[NIB_W-1]);
      bus.out_valid <= 1'b1;
    end else if (release_c) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla_serial_adder.sv
// Bench for cla_serial_adder: arithmetic reference model with per-cycle compare, plus directed vectors.
module tb_cla_serial_adder;

  localparam int NIBS16 = 4;
  localparam int BOUND  = 50;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_serial_adder_if #(.WIDTH(16)) b16 ();
  cla_serial_adder_if #(.WIDTH(4))  b4 ();

  cla_serial_adder #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
  cla_serial_adder #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

`ifdef SUBTRACT_EN
  logic sub_sel;
  assign b16.sub = sub_sel;
  assign b4.sub  = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: full-precision arithmetic on every accepted operand pair
  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic        seen = 1'b0;
  logic [15:0] m_b;
  logic        m_ci;
  logic [16:0] m_t;
  exp_t        m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      seen = 1'b0;
    end else begin
      if (b16.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'(b16.out_valid), 32'd0);
        end else begin
          if (!seen) begin
            chk("latency", 32'(cyc), 32'(q[0].acc + 1 + NIBS16));
            seen = 1'b1;
          end
          chk("model_sum",  32'(b16.sum),  32'(q[0].s));
          chk("model_cout", 32'(b16.cout), 32'(q[0].c));
          chk("model_ovf",  32'(b16.ovf),  32'(q[0].o));
          if (b16.out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (b16.in_valid && b16.in_ready) begin
        m_b  = b16.b;
        m_ci = b16.cin;
`ifdef SUBTRACT_EN
        if (b16.sub) begin
          m_b  = ~m_b;
          m_ci = 1'b1;
        end
`endif
        m_t     = 17'(b16.a) + 17'(m_b) + 17'(m_ci);
        m_e.s   = m_t[15:0];
        m_e.c   = m_t[16];
        m_e.o   = (b16.a[15] == m_b[15]) && (m_t[15] != b16.a[15]);
        m_e.acc = cyc;
        q.push_back(m_e);
      end
    end
  end

  // WIDTH=4 instance only ever sees 0x9 + 0x8
  int acc4_q[$];
  int ov4_first = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (b4.in_valid && b4.in_ready) acc4_q.push_back(cyc);
      if (b4.out_valid) begin
        if (ov4_first < 0) ov4_first = cyc;
        chk("w4_sum",  32'(b4.sum),  32'h1);
        chk("w4_cout", 32'(b4.cout), 32'h1);
        chk("w4_ovf",  32'(b4.ovf),  32'h1);
      end
    end
  end

  task automatic wait_ov16(input string nm);
    int k;
    k = 0;
    while (!b16.out_valid && k < BOUND) begin
      @(posedge clk); #2;
      k++;
    end
    if (k >= BOUND) chk({nm, "_timeout"}, 32'(b16.out_valid), 32'd1);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic [15:0] es, input logic ec, input logic eo, input string nm);
    int k;
    @(posedge clk); #2;
    b16.a = a; b16.b = b; b16.cin = ci;
    b16.in_valid = 1'b1; b16.out_ready = 1'b1;
    k = 0;
    while (!b16.in_ready && k < BOUND) begin
      @(posedge clk); #2;
      k++;
    end
    @(posedge clk); #2;
    b16.in_valid = 1'b0;
    wait_ov16(nm);
    chk({nm, "_sum"},  32'(b16.sum),  32'(es));
    chk({nm, "_cout"}, 32'(b16.cout), 32'(ec));
    chk({nm, "_ovf"},  32'(b16.ovf),  32'(eo));
    @(posedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.cin = 1'b0; b16.out_ready = 1'b0;
    b4.in_valid  = 1'b0; b4.a  = '0; b4.b  = '0; b4.cin  = 1'b0; b4.out_ready  = 1'b0;
`ifdef SUBTRACT_EN
    sub_sel = 1'b0;
`endif
    repeat (2) @(posedge clk); #2;
    chk("rst_in_ready",  32'(b16.in_ready),  32'd1);
    chk("rst_out_valid", 32'(b16.out_valid), 32'd0);
    chk("rst_sum",       32'(b16.sum),       32'd0);
    chk("rst_cout",      32'(b16.cout),      32'd0);
    chk("rst_ovf",       32'(b16.ovf),       32'd0);
    rst_n = 1'b1;

    op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "t1_wrap");
    op16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "t2_ovf");
    op16(16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0, "t2_cin");
    op16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "neg_ovf");

    // Backpressure: result held 5 cycles while a second request is offered
    @(posedge clk); #2;
    b16.a = 16'h00F0; b16.b = 16'h0F0F; b16.cin = 1'b0;
    b16.in_valid = 1'b1; b16.out_ready = 1'b0;
    @(posedge clk); #2;
    b16.in_valid = 1'b0;
    wait_ov16("bp");
    b16.a = 16'hFFFF; b16.b = 16'hFFFF; b16.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk("bp_out_valid", 32'(b16.out_valid), 32'd1);
      chk("bp_in_ready",  32'(b16.in_ready),  32'd0);
      chk("bp_sum",       32'(b16.sum),       32'h0FFF);
      chk("bp_cout",      32'(b16.cout),      32'd0);
      chk("bp_ovf",       32'(b16.ovf),       32'd0);
    end
    b16.in_valid = 1'b0; b16.out_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_release_valid", 32'(b16.out_valid), 32'd0);
    chk("bp_release_ready", 32'(b16.in_ready),  32'd1);

    // Reset during the second RUN cycle discards the operation
    @(posedge clk); #2;
    b16.a = 16'h4321; b16.b = 16'h1111; b16.cin = 1'b0; b16.in_valid = 1'b1;
    @(posedge clk); #2;
    b16.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  32'(b16.in_ready),  32'd1);
    chk("midrst_out_valid", 32'(b16.out_valid), 32'd0);
    chk("midrst_sum",       32'(b16.sum),       32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (6) @(posedge clk); #2;
    chk("midrst_no_pulse", 32'(b16.out_valid), 32'd0);
    op16(16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0, "after_rst");

`ifdef SUBTRACT_EN
    sub_sel = 1'b1;
    op16(16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    op16(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    sub_sel = 1'b0;
`endif

    // WIDTH=4: single RUN cycle, back-to-back operations every 3 cycles
    @(posedge clk); #2;
    b4.a = 4'h9; b4.b = 4'h8; b4.cin = 1'b0; b4.out_ready = 1'b1; b4.in_valid = 1'b1;
    k = 0;
    while (acc4_q.size() < 3 && k < BOUND) begin
      @(posedge clk); #2;
      k++;
    end
    b4.in_valid = 1'b0;
    chk("w4_accepts", 32'(acc4_q.size()), 32'd3);
    if (acc4_q.size() >= 3) begin
      chk("w4_period1", 32'(acc4_q[1] - acc4_q[0]), 32'd3);
      chk("w4_period2", 32'(acc4_q[2] - acc4_q[1]), 32'd3);
      chk("w4_latency", 32'(ov4_first), 32'(acc4_q[0] + 2));
    end
    repeat (5) @(posedge clk); #2;
    chk("w4_idle",       32'(b4.in_ready), 32'd1);
    chk("queue_drained", 32'(q.size()),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
